// File: rtl/jtframe_mist_pkg.sv
// Shared constants for the MiST board-glue block: joystick/status bit positions,
// reset timing and the audio format helper.
package jtframe_mist_pkg;

    localparam int JOY_DIR_W  = 4;
    localparam int JOY_OUT_W  = 10;
    localparam int JOY_COIN   = 10;
    localparam int JOY_START  = 11;
    localparam int JOY_PAUSE  = 12;

    localparam int ST_FLIP    = 1;
    localparam int ST_FX_LO   = 6;
    localparam int ST_FX_HI   = 7;
    localparam int ST_PSG     = 8;
    localparam int ST_FM      = 9;
    localparam int ST_TEST    = 10;

    // OSD menu order differs from the game's fx level order, hence the XOR.
    localparam logic [1:0] FXLEVEL_XOR = 2'b10;

    localparam int RST_CYCLES = 16;

    localparam logic [JOY_OUT_W-1:0] JOY_IDLE = '1;

    function automatic logic [15:0] snd_to_unsigned(input logic [15:0] din, input logic is_signed);
        return is_signed ? {~din[15], din[14:0]} : din;
    endfunction

endpackage

// File: rtl/jtframe_mist_frame_if.sv
// Bundle between the MiST IO controller side (master) and the board-glue block (slave).
interface jtframe_mist_frame_if;
    logic [31:0] status;
    logic        rst_req;
    logic        downloading;
    logic [31:0] joystick1;
    logic [31:0] joystick2;
    logic [15:0] snd_left;
    logic [15:0] snd_right;

    logic        rst;
    logic        game_rst;
    logic        game_rst_n;
    logic [9:0]  game_joystick1;
    logic [9:0]  game_joystick2;
    logic [9:0]  game_joystick3;
    logic [9:0]  game_joystick4;
    logic [3:0]  game_coin;
    logic [3:0]  game_start;
    logic        game_service;
    logic        dip_flip;
    logic        dip_test;
    logic        dip_pause;
    logic [1:0]  dip_fxlevel;
    logic        enable_fm;
    logic        enable_psg;
    logic        AUDIO_L;
    logic        AUDIO_R;
    logic        LED;

    modport master (
        output status, rst_req, downloading, joystick1, joystick2, snd_left, snd_right,
        input  rst, game_rst, game_rst_n,
        input  game_joystick1, game_joystick2, game_joystick3, game_joystick4,
        input  game_coin, game_start, game_service,
        input  dip_flip, dip_test, dip_pause, dip_fxlevel, enable_fm, enable_psg,
        input  AUDIO_L, AUDIO_R, LED
    );

    modport slave (
        input  status, rst_req, downloading, joystick1, joystick2, snd_left, snd_right,
        output rst, game_rst, game_rst_n,
        output game_joystick1, game_joystick2, game_joystick3, game_joystick4,
        output game_coin, game_start, game_service,
        output dip_flip, dip_test, dip_pause, dip_fxlevel, enable_fm, enable_psg,
        output AUDIO_L, AUDIO_R, LED
    );
endinterface

// File: rtl/jtframe_sigma_delta.sv
// First-order sigma-delta DAC: the carry out of a 16-bit accumulator is the 1-bit stream.
module jtframe_sigma_delta
    import jtframe_mist_pkg::*;
#(
    parameter int SIGNED_SND = 1
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [15:0] din,
    output logic        dout
);
    logic [15:0] w_u;
    logic [16:0] r_acc;

    assign w_u = snd_to_unsigned(din, SIGNED_SND != 0);

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= {1'b0, r_acc[15:0]} + {1'b0, w_u};
        end
    end

    assign dout = r_acc[16];

endmodule

// File: rtl/jtframe_mist_frame.sv
// MiST board glue: reset sequencing, OSD decode, input mapping, pause, LED and audio DACs.
// Define JTFRAME_STEREO_EN to feed the right DAC from snd_right; otherwise both use snd_left.
module jtframe_mist_frame
    import jtframe_mist_pkg::*;
#(
    parameter int SIGNED_SND = 1,
    parameter int BUTTONS    = 2,
    parameter int GAME_RSTW  = 8
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    jtframe_mist_frame_if.slave bus
);
    localparam int                   GAME_JOYW = BUTTONS + 4;
    localparam logic [GAME_RSTW-1:0] CNT_MAX   = '1;

    logic                 w_clear;
    logic                 w_clear_n;
    logic                 w_rst;
    logic [GAME_RSTW-1:0] r_cnt;

    // Any clear source restarts the whole sequence from zero.
    assign w_clear   = ~rst_n | bus.rst_req | bus.downloading;
    assign w_clear_n = ~w_clear;

    always_ff @(posedge clk_sys) begin
        if (w_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_rst          = r_cnt < GAME_RSTW'(RST_CYCLES);
    assign bus.rst        = w_rst;
    assign bus.game_rst   = r_cnt != CNT_MAX;
    assign bus.game_rst_n = r_cnt == CNT_MAX;

    logic       r_dip_flip;
    logic [1:0] r_dip_fxlevel;
    logic       r_enable_psg;
    logic       r_enable_fm;
    logic       r_dip_test;

    always_ff @(posedge clk_sys) begin
        if (w_clear) begin
            r_dip_flip    <= 1'b0;
            r_dip_fxlevel <= FXLEVEL_XOR;
            r_enable_psg  <= 1'b1;
            r_enable_fm   <= 1'b1;
            r_dip_test    <= 1'b1;
        end else begin
            r_dip_flip    <= bus.status[ST_FLIP];
            r_dip_fxlevel <= bus.status[ST_FX_HI:ST_FX_LO] ^ FXLEVEL_XOR;
            r_enable_psg  <= ~bus.status[ST_PSG];
            r_enable_fm   <= ~bus.status[ST_FM];
            r_dip_test    <= ~bus.status[ST_TEST];
        end
    end

    assign bus.dip_flip    = r_dip_flip;
    assign bus.dip_fxlevel = r_dip_fxlevel;
    assign bus.enable_psg  = r_enable_psg;
    assign bus.enable_fm   = r_enable_fm;
    assign bus.dip_test    = r_dip_test;

    logic [JOY_OUT_W-1:0] r_joy1;
    logic [JOY_OUT_W-1:0] r_joy2;

    generate
        for (genvar gi = 0; gi < JOY_OUT_W; gi++) begin : g_joy
            always_ff @(posedge clk_sys) begin
                if (w_clear) begin
                    r_joy1[gi] <= 1'b1;
                    r_joy2[gi] <= 1'b1;
                end else begin
                    r_joy1[gi] <= ~bus.joystick1[gi];
                    r_joy2[gi] <= ~bus.joystick2[gi];
                end
            end
        end
    endgenerate

    logic [1:0] r_coin;
    logic [1:0] r_start;

    always_ff @(posedge clk_sys) begin
        if (w_clear) begin
            r_coin  <= 2'b11;
            r_start <= 2'b11;
        end else begin
            r_coin  <= {~bus.joystick2[JOY_COIN],  ~bus.joystick1[JOY_COIN]};
            r_start <= {~bus.joystick2[JOY_START], ~bus.joystick1[JOY_START]};
        end
    end

    assign bus.game_joystick1 = r_joy1;
    assign bus.game_joystick2 = r_joy2;
    assign bus.game_joystick3 = JOY_IDLE;
    assign bus.game_joystick4 = JOY_IDLE;
    assign bus.game_coin      = {2'b11, r_coin};
    assign bus.game_start     = {2'b11, r_start};
    assign bus.game_service   = 1'b1;

    logic w_pause_btn;
    logic r_pause_prev;
    logic r_paused;

    assign w_pause_btn = bus.joystick1[JOY_PAUSE] | bus.joystick2[JOY_PAUSE];

    always_ff @(posedge clk_sys) begin
        r_pause_prev <= w_pause_btn;
        if (w_rst) begin
            r_paused <= 1'b0;
        end else if (w_pause_btn && !r_pause_prev) begin
            r_paused <= ~r_paused;
        end
    end

    assign bus.dip_pause = ~r_paused;

    logic r_led;

    always_ff @(posedge clk_sys) begin
        r_led <= bus.downloading;
    end

    assign bus.LED = r_led;

    logic [15:0] w_snd_r;

`ifdef JTFRAME_STEREO_EN
    assign w_snd_r = bus.snd_right;
`else
    assign w_snd_r = bus.snd_left;
`endif

    jtframe_sigma_delta #(.SIGNED_SND(SIGNED_SND)) u_dac_l (
        .clk_sys (clk_sys),
        .rst_n   (w_clear_n),
        .din     (bus.snd_left),
        .dout    (bus.AUDIO_L)
    );

    jtframe_sigma_delta #(.SIGNED_SND(SIGNED_SND)) u_dac_r (
        .clk_sys (clk_sys),
        .rst_n   (w_clear_n),
        .din     (w_snd_r),
        .dout    (bus.AUDIO_R)
    );

    logic [GAME_JOYW-1:0] w_unused_joyw;
    logic                 w_unused;

    assign w_unused_joyw = '0;
    assign w_unused = &{1'b0, w_unused_joyw, bus.status[31:11], bus.status[5:2], bus.status[0],
                        bus.joystick1[31:13], bus.joystick2[31:13]
`ifndef JTFRAME_STEREO_EN
                        , bus.snd_right
`endif
                       };

endmodule

// File: tb/tb_jtframe_mist_frame.sv
// Scoreboard bench for jtframe_mist_frame: expectations are queued with each stimulus and
// checked against the registered outputs one clock later.
module tb_jtframe_mist_frame;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    jtframe_mist_frame_if bus();

    jtframe_mist_frame #(.SIGNED_SND(1), .BUTTONS(2), .GAME_RSTW(8)) dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [31:0] obs_of(input string t);
        if      (t == "rst")     return 32'(bus.rst);
        else if (t == "grst")    return 32'(bus.game_rst);
        else if (t == "grstn")   return 32'(bus.game_rst_n);
        else if (t == "joy1")    return 32'(bus.game_joystick1);
        else if (t == "joy2")    return 32'(bus.game_joystick2);
        else if (t == "joy3")    return 32'(bus.game_joystick3);
        else if (t == "joy4")    return 32'(bus.game_joystick4);
        else if (t == "coin")    return 32'(bus.game_coin);
        else if (t == "start")   return 32'(bus.game_start);
        else if (t == "service") return 32'(bus.game_service);
        else if (t == "flip")    return 32'(bus.dip_flip);
        else if (t == "fx")      return 32'(bus.dip_fxlevel);
        else if (t == "fm")      return 32'(bus.enable_fm);
        else if (t == "psg")     return 32'(bus.enable_psg);
        else if (t == "test")    return 32'(bus.dip_test);
        else if (t == "pause")   return 32'(bus.dip_pause);
        else if (t == "led")     return 32'(bus.LED);
        else if (t == "audl")    return 32'(bus.AUDIO_L);
        else if (t == "audr")    return 32'(bus.AUDIO_R);
        else                     return 'x;
    endfunction

    task automatic push(input string t, input logic [31:0] e);
        sb_tag.push_back(t);
        sb_exp.push_back(e);
    endtask

    task automatic drain();
        string       t;
        logic [31:0] e;
        while (sb_tag.size() > 0) begin
            t = sb_tag.pop_front();
            e = sb_exp.pop_front();
            check_val(t, obs_of(t), e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure(input int limit, output int t_rst, output int t_grst);
        t_rst  = -1;
        t_grst = -1;
        for (int n = 1; n <= limit && t_grst < 0; n++) begin
            tick();
            if (t_rst < 0 && bus.rst == 1'b0) t_rst = n;
            if (bus.game_rst == 1'b0) t_grst = n;
        end
    endtask

    task automatic duty(input logic [15:0] l, input logic [15:0] r,
                        output int ones_l, output int ones_r, output int diffs);
        @(negedge clk);
        bus.snd_left  = l;
        bus.snd_right = r;
        bus.rst_req   = 1'b1;
        tick();
        push("audl", 0);
        push("audr", 0);
        drain();
        @(negedge clk);
        bus.rst_req = 1'b0;
        ones_l = 0;
        ones_r = 0;
        diffs  = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            ones_l += int'(bus.AUDIO_L);
            ones_r += int'(bus.AUDIO_R);
            if (bus.AUDIO_L != bus.AUDIO_R) diffs++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rst, t_grst, ol, orr, dif;

        rst_n           = 1'b0;
        bus.rst_req     = 1'b0;
        bus.downloading = 1'b0;
        bus.status      = 32'hFFFF_FFFE;
        bus.joystick1   = 32'h0000_0FFF;
        bus.joystick2   = 32'h0000_0FFF;
        bus.snd_left    = 16'h7FFF;
        bus.snd_right   = 16'h7FFF;

        // Reset state with non-idle inputs applied.
        repeat (5) tick();
        push("rst", 1);     push("grst", 1);   push("grstn", 0);
        push("joy1", 10'h3FF); push("joy2", 10'h3FF); push("joy3", 10'h3FF); push("joy4", 10'h3FF);
        push("coin", 4'hF); push("start", 4'hF); push("service", 1);
        push("flip", 0);    push("fx", 2'b10); push("fm", 1); push("psg", 1);
        push("test", 1);    push("pause", 1);  push("led", 0);
        push("audl", 0);    push("audr", 0);
        drain();

        @(negedge clk);
        rst_n         = 1'b1;
        bus.status    = 32'h0;
        bus.joystick1 = 32'h0;
        bus.joystick2 = 32'h0;
        bus.snd_left  = 16'h0;
        bus.snd_right = 16'h0;
        measure(100, t_rst, t_grst);
        check_val("rst_fall", 32'(t_rst), 32'd16);
        push("grst", 1);
        drain();

        // Mid-count download pulse restarts the sequencer.
        @(negedge clk);
        bus.downloading = 1'b1;
        tick();
        push("led", 1); push("rst", 1); push("grst", 1); push("grstn", 0);
        drain();
        @(negedge clk);
        bus.downloading = 1'b0;
        measure(400, t_rst, t_grst);
        check_val("rst_fall_restart", 32'(t_rst), 32'd16);
        check_val("grst_fall_restart", 32'(t_grst), 32'd255);
        push("grstn", 1); push("led", 0);
        drain();

        // Status decode patterns.
        @(negedge clk); bus.status = 32'h0000_03C2; tick();
        push("flip", 1); push("fx", 2'b01); push("psg", 0); push("fm", 0); push("test", 1);
        drain();
        @(negedge clk); bus.status = 32'h0000_0400; tick();
        push("flip", 0); push("fx", 2'b10); push("psg", 1); push("fm", 1); push("test", 0);
        drain();
        @(negedge clk); bus.status = 32'h0000_0040; tick();
        push("fx", 2'b11); push("test", 1);
        drain();

        // Joystick, coin and start mapping.
        @(negedge clk); bus.joystick1 = 32'h0000_0C11; bus.joystick2 = 32'h0; tick();
        push("joy1", 10'h3EE); push("joy2", 10'h3FF); push("coin", 4'b1110); push("start", 4'b1110);
        push("joy3", 10'h3FF); push("joy4", 10'h3FF); push("service", 1);
        drain();
        @(negedge clk); bus.joystick1 = 32'h0; bus.joystick2 = 32'h0000_043F; tick();
        push("joy1", 10'h3FF); push("joy2", 10'h3C0); push("coin", 4'b1101); push("start", 4'b1111);
        drain();
        @(negedge clk); bus.joystick2 = 32'h0; tick();

        // Pause: a held button toggles once.
        @(negedge clk); bus.joystick2 = 32'h0000_1000; tick();
        push("pause", 0); drain();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); tick();
            push("pause", 0); drain();
        end
        @(negedge clk); bus.joystick2 = 32'h0; tick();
        push("pause", 0); drain();
        @(negedge clk); bus.joystick1 = 32'h0000_1000; tick();
        push("pause", 1); drain();
        tick(); push("pause", 1); drain();
        @(negedge clk); bus.joystick1 = 32'h0; tick();
        @(negedge clk); bus.joystick2 = 32'h0000_1000; tick();
        push("pause", 0); drain();
        @(negedge clk); bus.joystick2 = 32'h0; bus.rst_req = 1'b1; tick();
        push("rst", 1); drain();
        @(negedge clk); bus.rst_req = 1'b0; tick();
        push("pause", 1); drain();

        // Audio duty cycles, signed input format.
        duty(16'h0000, 16'h0000, ol, orr, dif);
        check_val("duty_0000", 32'(ol), 32'd512);
        duty(16'h8000, 16'h8000, ol, orr, dif);
        check_val("duty_8000", 32'(ol), 32'd0);
        duty(16'h7FFF, 16'h7FFF, ol, orr, dif);
        check_val("duty_7fff", 32'(ol), 32'd1023);

        duty(16'h4000, 16'hC000, ol, orr, dif);
        check_val("duty_l_4000", 32'(ol), 32'd768);
`ifdef JTFRAME_STEREO_EN
        check_val("duty_r_c000", 32'(orr), 32'd256);
`else
        check_val("duty_r_mono", 32'(orr), 32'd768);
        check_val("mono_diffs", 32'(dif), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
